// File: rtl/sd_div_pkg.sv
// Shared definitions for the signed-digit quotient path: the digit encoding,
// the collector state type, and a helper that classifies a digit as zero.
package sd_div_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } sdq_state_e;

  // Both 2'b00 and 2'b11 carry the digit value 0.
  function automatic logic sd_is_zero(input logic [1:0] digit);
    return (digit == 2'b00) || (digit == 2'b11);
  endfunction

endpackage

// File: rtl/sd_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the pair
// (Q, QM = Q-1) without a carry chain. Only the low W-1 bits of Q and QM
// are needed because the append shifts the old MSB out.
module sd_otf_step
  import sd_div_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-2:0] q_low,
  input  logic [W-2:0] qm_low,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_nxt,
  output logic [W-1:0] qm_nxt
);

  // Select the shifted source register and appended bit for each digit value.
  always_comb begin
    q_nxt  = {q_low, 1'b0};
    qm_nxt = {qm_low, 1'b1};
    if (sd_is_zero(digit)) begin
      q_nxt  = {q_low, 1'b0};
      qm_nxt = {qm_low, 1'b1};
    end else if (digit == SD_POS) begin
      q_nxt  = {q_low, 1'b1};
      qm_nxt = {q_low, 1'b0};
    end else begin
      q_nxt  = {qm_low, 1'b1};
      qm_nxt = {qm_low, 1'b0};
    end
  end

endmodule

// File: rtl/sd_quotient_collector.sv
// Collects DIGITS radix-2 signed quotient digits (MSD first) and presents the
// two's-complement result on a valid/ready port.
// Optional build macro SDQ_SKID_EN: lets collection continue while a result
// waits; a second completed frame is parked in Q until the output drains.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// COLLECT | q_rdy=1, digits accepted and converted into Q/QM
// HOLD    | q_rdy=0; default: result waiting on res_rdy;
//         | skid: a finished frame is parked in Q waiting for the output slot
module sd_quotient_collector
  import sd_div_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic [1:0]        q_digit,
  input  logic              q_vld,
  output logic              q_rdy,
  output logic [DIGITS:0]   res,
  output logic              res_neg,
  output logic              res_zero,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [CNT_W-1:0]  frame_cnt
);

  sdq_state_e state, state_nxt;

  logic [DIGITS:0] q_reg, qm_reg;
  logic [DIGITS:0] q_nxt, qm_nxt;
  logic            accept;
  logic            last_digit;
  logic            load_res;
  logic            park;
  logic            unpark;
  logic            clr_vld;

  sd_otf_step #(.W(DIGITS + 1)) u_step (
    .q_low  (q_reg[DIGITS-1:0]),
    .qm_low (qm_reg[DIGITS-1:0]),
    .digit  (q_digit),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt)
  );

  assign q_rdy      = (state == COLLECT);
  assign accept     = q_vld && q_rdy;
  assign last_digit = (frame_cnt == CNT_W'(DIGITS - 1));

  // State register.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) state <= COLLECT;
    else            state <= state_nxt;
  end

  // Next state and datapath control strobes.
  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    park      = 1'b0;
    unpark    = 1'b0;
    clr_vld   = 1'b0;
    case (state)
      COLLECT: begin
`ifdef SDQ_SKID_EN
        if (accept && last_digit) begin
          if (!res_vld || res_rdy) begin
            load_res = 1'b1;
          end else begin
            park      = 1'b1;
            state_nxt = HOLD;
          end
        end else if (res_vld && res_rdy) begin
          clr_vld = 1'b1;
        end
`else
        if (accept && last_digit) begin
          load_res  = 1'b1;
          state_nxt = HOLD;
        end
`endif
      end
      HOLD: begin
`ifdef SDQ_SKID_EN
        // Output slot frees this edge; the parked frame moves straight in.
        if (res_rdy) begin
          unpark    = 1'b1;
          state_nxt = COLLECT;
        end
`else
        if (res_rdy) begin
          clr_vld   = 1'b1;
          state_nxt = COLLECT;
        end
`endif
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Conversion registers and digit counter.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      q_reg     <= '0;
      qm_reg    <= '1;
      frame_cnt <= '0;
    end else if (accept) begin
      if (last_digit) begin
        frame_cnt <= '0;
        if (park) begin
          q_reg <= q_nxt;
        end else begin
          q_reg  <= '0;
          qm_reg <= '1;
        end
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
        q_reg     <= q_nxt;
        qm_reg    <= qm_nxt;
      end
    end else if (unpark) begin
      q_reg  <= '0;
      qm_reg <= '1;
    end
  end

  // Result register with its flags, loaded together so they always agree.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      res      <= '0;
      res_neg  <= 1'b0;
      res_zero <= 1'b1;
      res_vld  <= 1'b0;
    end else if (load_res) begin
      res      <= q_nxt;
      res_neg  <= q_nxt[DIGITS];
      res_zero <= (q_nxt == '0);
      res_vld  <= 1'b1;
    end else if (unpark) begin
      res      <= q_reg;
      res_neg  <= q_reg[DIGITS];
      res_zero <= (q_reg == '0);
    end else if (clr_vld) begin
      res_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_quotient_collector.sv
module tb_sd_quotient_collector;

  localparam int DIGITS = 4;
  localparam int CNT_W  = $clog2(DIGITS + 1);
`ifdef SDQ_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             asyn_reset = 1'b1;
  logic [1:0]       q_digit = 2'b00;
  logic             q_vld = 1'b0;
  logic             q_rdy;
  logic [DIGITS:0]  res;
  logic             res_neg;
  logic             res_zero;
  logic             res_vld;
  logic             res_rdy = 1'b0;
  logic [CNT_W-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_quotient_collector #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .q_digit    (q_digit),
    .q_vld      (q_vld),
    .q_rdy      (q_rdy),
    .res        (res),
    .res_neg    (res_neg),
    .res_zero   (res_zero),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .frame_cnt  (frame_cnt)
  );

  // Presents one digit after `gap` idle cycles (with a decoy digit while
  // q_vld is low) and returns 1 time unit after the accepting edge.
  task automatic send_digit(input logic [1:0] d, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      @(negedge clk);
      q_vld = 1'b0;
      q_digit = ~d;
    end
    @(negedge clk);
    q_digit = d;
    q_vld   = 1'b1;
    while (!q_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!q_rdy) begin
      checks++; errors++;
      $display("FAIL send_digit_timeout: q_rdy=%b required 1", q_rdy);
    end
    @(posedge clk);
    #1;
    q_vld = 1'b0;
  endtask

  // Sends a full frame with res_rdy=1 and checks the one-cycle result pulse.
  task automatic run_frame(input string name, input logic [1:0] d0, input logic [1:0] d1,
                           input logic [1:0] d2, input logic [1:0] d3,
                           input logic [DIGITS:0] exp_res, input logic exp_neg,
                           input logic exp_zero, input logic rnd);
    logic [1:0] dv [4];
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    res_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_digit(dv[i], rnd ? (($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0) : 0);
    @(negedge clk);
    checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL %s res_vld: got %b want 1", name, res_vld); end
    checks++; if (res !== exp_res) begin errors++; $display("FAIL %s res: got %b want %b", name, res, exp_res); end
    checks++; if (res_neg !== exp_neg) begin errors++; $display("FAIL %s res_neg: got %b want %b", name, res_neg, exp_neg); end
    checks++; if (res_zero !== exp_zero) begin errors++; $display("FAIL %s res_zero: got %b want %b", name, res_zero, exp_zero); end
    checks++; if (q_rdy !== SKID) begin errors++; $display("FAIL %s q_rdy_bubble: got %b want %b", name, q_rdy, SKID); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL %s frame_cnt_wrap: got %0d want 0", name, frame_cnt); end
    @(negedge clk);
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL %s res_vld_drop: got %b want 0", name, res_vld); end
    checks++; if (q_rdy !== 1'b1) begin errors++; $display("FAIL %s q_rdy_return: got %b want 1", name, q_rdy); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (q_rdy !== 1'b1) begin errors++; $display("FAIL reset q_rdy: got %b want 1", q_rdy); end
    checks++; if (res !== '0) begin errors++; $display("FAIL reset res: got %b want 0", res); end
    checks++; if (res_neg !== 1'b0) begin errors++; $display("FAIL reset res_neg: got %b want 0", res_neg); end
    checks++; if (res_zero !== 1'b1) begin errors++; $display("FAIL reset res_zero: got %b want 1", res_zero); end
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset res_vld: got %b want 0", res_vld); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset frame_cnt: got %0d want 0", frame_cnt); end
    asyn_reset = 1'b0;
  endtask

  task automatic test_conversion();
    run_frame("mixed",   2'b10, 2'b00, 2'b01, 2'b10, 5'b00111, 1'b0, 1'b0, 1'b0);
    run_frame("all_neg", 2'b01, 2'b01, 2'b01, 2'b01, 5'b10001, 1'b1, 1'b0, 1'b0);
    run_frame("zeros",   2'b00, 2'b11, 2'b00, 2'b11, 5'b00000, 1'b0, 1'b1, 1'b0);
    run_frame("all_pos", 2'b10, 2'b10, 2'b10, 2'b10, 5'b01111, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    res_rdy = 1'b0;
    send_digit(2'b10, 0); send_digit(2'b10, 0); send_digit(2'b00, 0); send_digit(2'b00, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (res !== 5'b01100) begin errors++; $display("FAIL hold res c%0d: got %b want 01100", c, res); end
      checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL hold res_vld c%0d: got %b want 1", c, res_vld); end
      checks++; if (q_rdy !== SKID) begin errors++; $display("FAIL hold q_rdy c%0d: got %b want %b", c, q_rdy, SKID); end
    end
`ifdef SDQ_SKID_EN
    send_digit(2'b01, 0); send_digit(2'b00, 0); send_digit(2'b00, 0); send_digit(2'b00, 0);
    @(negedge clk);
    checks++; if (q_rdy !== 1'b0) begin errors++; $display("FAIL skid q_rdy_full: got %b want 0", q_rdy); end
    checks++; if (res !== 5'b01100) begin errors++; $display("FAIL skid res_first: got %b want 01100", res); end
    res_rdy = 1'b1;
    @(negedge clk);
    checks++; if (res !== 5'b11000) begin errors++; $display("FAIL skid res_second: got %b want 11000", res); end
    checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL skid res_vld_second: got %b want 1", res_vld); end
    checks++; if (res_neg !== 1'b1) begin errors++; $display("FAIL skid res_neg_second: got %b want 1", res_neg); end
    checks++; if (q_rdy !== 1'b1) begin errors++; $display("FAIL skid q_rdy_resume: got %b want 1", q_rdy); end
    @(negedge clk);
`else
    res_rdy = 1'b1;
    @(negedge clk);
`endif
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL hold release res_vld: got %b want 0", res_vld); end
    checks++; if (q_rdy !== 1'b1) begin errors++; $display("FAIL hold release q_rdy: got %b want 1", q_rdy); end
  endtask

  task automatic test_mid_reset();
    res_rdy = 1'b1;
    send_digit(2'b01, 0); send_digit(2'b00, 0);
    checks++; if (frame_cnt !== 3'd2) begin errors++; $display("FAIL midrst cnt_before: got %0d want 2", frame_cnt); end
    @(negedge clk);
    asyn_reset = 1'b1;
    #2;
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL midrst cnt_async: got %0d want 0", frame_cnt); end
    checks++; if (q_rdy !== 1'b1) begin errors++; $display("FAIL midrst q_rdy: got %b want 1", q_rdy); end
    #1;
    asyn_reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      send_digit(2'b10, 0);
      checks++; if (frame_cnt !== CNT_W'(i)) begin errors++; $display("FAIL midrst cnt%0d: got %0d want %0d", i, frame_cnt, i); end
    end
    send_digit(2'b10, 0);
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL midrst cnt_wrap: got %0d want 0", frame_cnt); end
    checks++; if (res !== 5'b01111) begin errors++; $display("FAIL midrst res: got %b want 01111", res); end
    checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL midrst res_vld: got %b want 1", res_vld); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random_gaps();
    for (int r = 0; r < 3; r++) begin
      run_frame("rnd_mixed", 2'b10, 2'b00, 2'b01, 2'b10, 5'b00111, 1'b0, 1'b0, 1'b1);
      run_frame("rnd_neg",   2'b01, 2'b01, 2'b01, 2'b01, 5'b10001, 1'b1, 1'b0, 1'b1);
      run_frame("rnd_alt",   2'b01, 2'b10, 2'b11, 2'b01, 5'b11011, 1'b1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_conversion();
    test_hold();
    test_mid_reset();
    test_random_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sd_quotient_collector.md
# sd_quotient_collector

Downstream neighbour of the digit-serial divider control stage: accepts the signed-digit quotient stream one radix-2 digit per valid/ready handshake and converts it on the fly into a two's-complement integer. After `DIGITS` digits it presents the completed quotient word on a valid/ready output port. No carry-propagate adder is used; conversion is incremental, one digit per accepted handshake.

## Interface
- `DIGITS`, 8: quotient digits per frame, MSD first; legal range 2..64.
- `CNT_W`, `$clog2(DIGITS+1)`: digit counter width.

Ports (clock and reset first):
- `clk` in 1: clock; all state changes on the rising edge.
- `asyn_reset` in 1: reset, asynchronous, active-high; clock `clk`.
- `q_digit` in 2: signed digit; `2'b10` = +1, `2'b01` = −1, `2'b00` and `2'b11` = 0.
- `q_vld` in 1: `q_digit` valid; wired to the divider's `data_out_vld`.
- `q_rdy` out 1: collector can accept a digit; drives the divider's `data_out_rdy`.
- `res` out `DIGITS+1`: signed quotient, integer value Σ qᵢ·2^(DIGITS−1−i).
- `res_neg` out 1: `res` < 0.
- `res_zero` out 1: `res` == 0.
- `res_vld` out 1: `res`/flags valid.
- `res_rdy` in 1: consumer accepts the result.
- `frame_cnt` out `CNT_W`: digits accepted in the current frame.

## Operation
- Two registers `Q`, `QM` (`DIGITS+1` bits each) hold the converted prefix and prefix−1. Reset/frame-start values: `Q`=0, `QM`=all ones (−1).
- On each accepted digit (`q_vld && q_rdy`):
  - +1: `Q`←{`Q`,1}, `QM`←{`Q`,0}.
  - 0: `Q`←{`Q`,0}, `QM`←{`QM`,1}.
  - −1: `Q`←{`QM`,1}, `QM`←{`QM`,0}.
- Concatenation discards the MSB; no overflow is possible within `DIGITS+1` bits.
- FSM states:
  - COLLECT: `q_rdy`=1. Each accept increments `frame_cnt`. The accept that makes the count equal `DIGITS` copies the converted value into `res`, sets `res_vld`, clears `frame_cnt`, reinitialises `Q`/`QM`, and moves to HOLD.
  - HOLD: `q_rdy`=0. `res_vld`=1 with `res` stable. On `res_rdy`, clear `res_vld` and return to COLLECT.
- `res_neg` = `res[DIGITS]`; `res_zero` = (`res`==0). Both are registered with `res` and are meaningful only while `res_vld`=1.
- Reset values: `q_rdy`=1 (COLLECT), `res`=0, `res_neg`=0, `res_zero`=1, `res_vld`=0, `frame_cnt`=0, `Q`=0, `QM`=−1.
- Reset mid-frame discards partial digits; the next accepted digit is digit 0 of a new frame.

## Timing
- `q_rdy` is a function of registered state only; no combinational path from `q_vld` or `res_rdy` to `q_rdy`.
- Latency: `res_vld` rises on the clock edge that accepts the last digit, so it is visible in the following cycle.
- The result handshake completes on the edge where `res_vld && res_rdy`. `q_rdy` returns high in the next cycle, giving one bubble cycle per frame without the skid feature.
- `q_vld` while `q_rdy`=0 is ignored; the digit must be held by the producer.
- Throughput: one digit per cycle in COLLECT.

## Configuration
- `SDQ_SKID_EN` defined: adds a one-entry result buffer. On frame completion the converter returns to COLLECT immediately. `q_rdy` drops only when the buffer is full and a further frame has completed and is waiting for it. If the result handshake and a frame completion fall on the same edge, the buffer reloads with the new frame and `res_vld` stays high.
- Undefined: the behaviour is exactly as described above, with collection stalled in HOLD.

## Structure
- Package `sd_div_pkg`: digit encoding constants `SD_POS`=2'b10, `SD_NEG`=2'b01, `SD_ZERO`=2'b00; FSM state typedef (COLLECT, HOLD); helper function `sd_is_zero`.
- Sub-module `sd_otf_step`: combinational single-digit on-the-fly update, (`Q`, `QM`, `digit`) → (`Q'`, `QM'`). It is instantiated once in the collector.

## Test plan
- `DIGITS`=4, digits +1,0,−1,+1 with `res_rdy`=1 → `res`=5'b00111 (7), `res_neg`=0, `res_vld` high for 1 cycle.
- `DIGITS`=4, digits −1,−1,−1,−1 → `res`=5'b10001 (−15), `res_neg`=1.
- `DIGITS`=4, digits 00,11,00,11 → `res`=0, `res_zero`=1.
- Hold `res_rdy`=0 for 3 cycles after frame completion → `res` stable, `q_rdy`=0 throughout (skid off). With `SDQ_SKID_EN`, the next 4 digits are accepted and `q_rdy` drops only after the second frame completes.
- Assert `asyn_reset` after 2 digits, then send +1,+1,+1,+1 → `res`=15 and `frame_cnt` counts 1..3 then 0.
- Toggle `q_vld` randomly (50%) → same results as back-to-back input; no digit is lost or duplicated.
